// File: rtl/expgolomb_symbol_decoder.sv
// Order-0 exponential-Golomb symbol decoder: one symbol per LSB-first window, valid/ready output.
// Define EXPGOLOMB_SYMBOL_DECODER_STATS_EN to add the sym_count/bit_count statistics outputs.
module expgolomb_symbol_decoder #(
  parameter int WIDTH_IN      = 64,
  parameter int LOG2_WIDTH_IN = $clog2(WIDTH_IN),
  parameter int MAX_ZEROS     = (WIDTH_IN - 2) / 2,
  parameter int VALUE_WIDTH   = MAX_ZEROS + 1,
  parameter int POP_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     win_ready,
  input  logic [WIDTH_IN-1:0]      win,
  output logic [LOG2_WIDTH_IN-1:0] pop,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  output logic [VALUE_WIDTH-1:0]   sym,
  output logic [LOG2_WIDTH_IN-1:0] sym_len,
  output logic                     error
`ifdef EXPGOLOMB_SYMBOL_DECODER_STATS_EN
  ,
  output logic [31:0]              sym_count,
  output logic [39:0]              bit_count
`endif
);

  localparam int CNT_W = (POP_LATENCY > 1) ? $clog2(POP_LATENCY) : 1;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_ERR} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [CNT_W-1:0]         wait_cnt;
  logic [LOG2_WIDTH_IN-1:0] zeros;
  logic [MAX_ZEROS-1:0]     tail;
  logic [MAX_ZEROS-1:0]     tail_rev;
  logic [VALUE_WIDTH-1:0]   field;
  logic [VALUE_WIDTH-1:0]   base;
  logic [VALUE_WIDTH-1:0]   dec_sym;
  logic [LOG2_WIDTH_IN-1:0] code_len;
  logic                     code_ok;
  logic                     trigger;
  logic                     load;

  // Leading-zero count; saturates at MAX_ZEROS+1 when no terminator is in range.
  always_comb begin
    zeros = LOG2_WIDTH_IN'(MAX_ZEROS + 1);
    for (int i = MAX_ZEROS; i >= 0; i--) begin
      if (win[i]) zeros = LOG2_WIDTH_IN'(i);
    end
  end

  // The info field arrives MSB-first, so bit-reverse it and right-align its n bits.
  assign tail = MAX_ZEROS'((win >> zeros) >> 1);

  always_comb begin
    tail_rev = '0;
    for (int k = 0; k < MAX_ZEROS; k++) begin
      tail_rev[MAX_ZEROS-1-k] = tail[k];
    end
  end

  assign field    = VALUE_WIDTH'(tail_rev >> (LOG2_WIDTH_IN'(MAX_ZEROS) - zeros));
  assign base     = (VALUE_WIDTH'(1) << zeros) - VALUE_WIDTH'(1);
  assign dec_sym  = base + field;
  assign code_ok  = (zeros <= LOG2_WIDTH_IN'(MAX_ZEROS));
  assign code_len = {zeros[LOG2_WIDTH_IN-2:0], 1'b1};
  assign trigger  = win_ready && (!sym_valid || sym_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        wait_cnt <= CNT_W'(POP_LATENCY - 1);
      end else if (state == S_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (trigger) state_next = code_ok ? S_WAIT : S_ERR;
      end
      S_WAIT: begin
        if (wait_cnt == '0) state_next = S_FETCH;
      end
      default: state_next = S_ERR;
    endcase
  end

  // Pop is gated by reset so nothing is consumed in a reset cycle.
  always_comb begin
    load  = 1'b0;
    pop   = '0;
    error = 1'b0;
    case (state)
      S_FETCH: load  = rst && trigger && code_ok;
      S_ERR:   error = 1'b1;
      default: ;
    endcase
    if (load) pop = code_len;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sym_valid <= 1'b0;
      sym       <= '0;
      sym_len   <= '0;
    end else if (load) begin
      sym_valid <= 1'b1;
      sym       <= dec_sym;
      sym_len   <= code_len;
    end else if (sym_ready) begin
      sym_valid <= 1'b0;
    end
  end

`ifdef EXPGOLOMB_SYMBOL_DECODER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      sym_count <= '0;
      bit_count <= '0;
    end else begin
      if (sym_valid && sym_ready) sym_count <= sym_count + 32'd1;
      bit_count <= bit_count + 40'(pop);
    end
  end
`endif

endmodule

// File: tb/tb_expgolomb_symbol_decoder.sv
// Randomized bench for expgolomb_symbol_decoder against a transaction-level reference model.
module tb_expgolomb_symbol_decoder;

  localparam int MZ = 31;
  localparam int PL = 1;
  localparam logic [63:0] N31_WIN = 64'h7FFF_FFFF_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        win_ready;
  logic [63:0] win;
  logic [5:0]  pop;
  logic        sym_valid;
  logic        sym_ready;
  logic [31:0] sym;
  logic [5:0]  sym_len;
  logic        error;
`ifdef EXPGOLOMB_SYMBOL_DECODER_STATS_EN
  logic [31:0] sym_count;
  logic [39:0] bit_count;
`endif

  int checks = 0;
  int passed = 0;

  expgolomb_symbol_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .win_ready (win_ready),
    .win       (win),
    .pop       (pop),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym       (sym),
    .sym_len   (sym_len),
    .error     (error)
`ifdef EXPGOLOMB_SYMBOL_DECODER_STATS_EN
    ,
    .sym_count (sym_count),
    .bit_count (bit_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Drive one cycle's inputs just after the edge, then wait to the sampling point.
  task automatic applyStimulus(input logic r, input logic [63:0] w, input logic wr, input logic sr);
    @(posedge clk);
    #1;
    rst       = r;
    win       = w;
    win_ready = wr;
    sym_ready = sr;
    @(negedge clk);
  endtask

  function automatic void ref_decode(input logic [63:0] w, output bit legal,
                                     output longint unsigned val, output int len);
    int n = 0;
    longint unsigned fld = 0;
    while (n < 64 && w[n] == 1'b0) n++;
    legal = (n <= MZ);
    val   = 0;
    len   = 0;
    if (legal) begin
      for (int k = 0; k < n; k++) fld = fld * 2 + longint'(w[n+1+k]);
      val = (64'd1 << n) - 1 + fld;
      len = 2 * n + 1;
    end
  endfunction

  function automatic logic [63:0] rand_win();
    logic [63:0] w;
    int n;
    w = {$urandom, $urandom};
    if ($urandom_range(0, 99) == 0) begin
      w[31:0] = '0;
      return w;
    end
    n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MZ) : $urandom_range(0, 3);
    for (int i = 0; i < n; i++) w[i] = 1'b0;
    w[n] = 1'b1;
    return w;
  endfunction

  // Reference model: output slot, cooldown after a pop, sticky error, statistics.
  bit              model_en = 0;
  bit              m_full   = 0;
  bit              m_err    = 0;
  int              m_cool   = 0;
  longint unsigned m_sym    = 0;
  int              m_len    = 0;
  longint unsigned m_hs     = 0;
  longint unsigned m_bits   = 0;

  always @(negedge clk) begin : cmp
    bit              legal;
    longint unsigned val;
    int              len;
    bit              can;
    int              exp_pop;
    if (model_en) begin
      ref_decode(win, legal, val, len);
      can     = rst && !m_err && m_cool == 0 && win_ready && (!m_full || sym_ready);
      exp_pop = (can && legal) ? len : 0;
      checkOutput("pop", pop, exp_pop);
      checkOutput("sym_valid", sym_valid, m_full);
      checkOutput("error", error, m_err);
      if (m_full) begin
        checkOutput("sym", sym, m_sym);
        checkOutput("sym_len", sym_len, m_len);
      end
`ifdef EXPGOLOMB_SYMBOL_DECODER_STATS_EN
      checkOutput("sym_count", sym_count, m_hs & 64'hFFFF_FFFF);
      checkOutput("bit_count", bit_count, m_bits & 64'hFF_FFFF_FFFF);
`endif
      if (!rst) begin
        m_full = 0; m_err = 0; m_cool = 0; m_sym = 0; m_len = 0; m_hs = 0; m_bits = 0;
      end else begin
        if (m_full && sym_ready) m_hs++;
        m_bits += longint'(exp_pop);
        if (exp_pop != 0) begin
          m_full = 1; m_sym = val; m_len = len; m_cool = PL;
        end else begin
          if (m_full && sym_ready) m_full = 0;
          if (m_cool > 0) m_cool--;
          if (can && !legal) m_err = 1;
        end
      end
    end
  end

  initial begin
    rst = 1'b0; win = '0; win_ready = 1'b0; sym_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_en = 1;

    applyStimulus(1'b0, 64'h1, 1'b1, 1'b1);
    checkOutput("reset pop", pop, 0);
    checkOutput("reset sym_valid", sym_valid, 0);
    checkOutput("reset sym", sym, 0);
    checkOutput("reset sym_len", sym_len, 0);
    checkOutput("reset error", error, 0);

    applyStimulus(1'b1, 64'h1, 1'b1, 1'b1);
    checkOutput("win1 pop", pop, 1);
    applyStimulus(1'b1, 64'h6, 1'b1, 1'b1);
    checkOutput("win1 wait pop", pop, 0);
    checkOutput("win1 sym_valid", sym_valid, 1);
    checkOutput("win1 sym", sym, 0);
    checkOutput("win1 sym_len", sym_len, 1);
    applyStimulus(1'b1, 64'h6, 1'b1, 1'b1);
    checkOutput("win6 pop", pop, 3);
    applyStimulus(1'b1, 64'h2, 1'b1, 1'b1);
    checkOutput("win6 sym", sym, 2);
    checkOutput("win6 sym_len", sym_len, 3);
    applyStimulus(1'b1, 64'h2, 1'b1, 1'b1);
    checkOutput("win2 pop", pop, 3);
    applyStimulus(1'b1, N31_WIN, 1'b1, 1'b1);
    checkOutput("win2 sym", sym, 1);
    applyStimulus(1'b1, N31_WIN, 1'b1, 1'b1);
    checkOutput("n31 pop", pop, 63);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 64'h1, 1'b1, 1'b0);
      checkOutput("stall pop", pop, 0);
      checkOutput("stall sym", sym, 32'hFFFF_FFFE);
      checkOutput("stall sym_len", sym_len, 63);
    end
    applyStimulus(1'b1, 64'h1, 1'b1, 1'b1);
    checkOutput("drain+load pop", pop, 1);
    applyStimulus(1'b1, 64'h0, 1'b1, 1'b1);
    checkOutput("drain+load sym_valid", sym_valid, 1);
    checkOutput("drain+load sym", sym, 0);

    applyStimulus(1'b1, 64'h0, 1'b1, 1'b1);
    checkOutput("zero win pop", pop, 0);
    checkOutput("zero win error", error, 0);
    applyStimulus(1'b1, 64'h1, 1'b1, 1'b1);
    checkOutput("err pop", pop, 0);
    checkOutput("err flag", error, 1);
    applyStimulus(1'b1, 64'h1, 1'b1, 1'b1);
    checkOutput("err sticky", error, 1);
    applyStimulus(1'b0, 64'h1, 1'b1, 1'b1);
    checkOutput("rst cycle pop", pop, 0);
    applyStimulus(1'b1, 64'h1, 1'b1, 1'b1);
    checkOutput("post rst error", error, 0);
    checkOutput("post rst pop", pop, 1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) != 0, rand_win(), i[0], $urandom_range(0, 3) != 0);
      if (!win_ready) checkOutput("toggle idle pop", pop, 0);
    end

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 79) != 0, rand_win(),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    model_en = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
